fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side consumer stage placed directly downstream of the synchronous FIFO.
- Drives the FIFO read enable and captures words from the FIFO's registered data output, which has 1-cycle read latency.
- Re-presents the words on a valid/ready stream interface, using a small credit-controlled holding buffer.
- Sustains one word per cycle, never loses a word, and never reads an empty FIFO.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the FIFO data_out width.
- BUF_DEPTH, 2, holding-buffer entries; must be >= 2 for full throughput (1 is legal but halves throughput).
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; same net that resets the FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  FIFO_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
- fifo_rd_en  out  1  FIFO read enable (combinational).
- m_data  out  FIFO_WIDTH  stream data, taken from the buffer head.
- m_valid  out  1  stream valid.
- m_ready  in  1  downstream ready.
- buf_count  out  clog2(BUF_DEPTH+1)  number of words held in the buffer.
- words_out  out  CNT_WIDTH  count of completed stream handshakes.

Behaviour:
- Reset (asynchronous, rst_n=0), immediately:
  - buffer emptied: buf_count=0, m_valid=0, m_data=0;
  - in-flight flag cleared; words_out=0;
  - fifo_rd_en forced 0 while rst_n=0.
- Handshake definitions:
  - pop = m_valid & m_ready.
  - inflight = a register holding last cycle's fifo_rd_en.
- Credit rule (combinational):
  - fifo_rd_en = rst_n & !fifo_empty & ((buf_count + inflight - pop) < BUF_DEPTH).
  - The buffer therefore can never overflow, and a read is never issued while fifo_empty=1.
- Capture:
  - When inflight=1, fifo_data_out is written into the buffer tail at the next rising edge.
  - No qualification is applied; the read was guaranteed non-empty when issued.
- Buffer organisation:
  - Circular, with head/tail pointers that wrap modulo BUF_DEPTH.
  - m_data = entry[head]; m_valid = (buf_count != 0).
- Simultaneous capture and pop in the same cycle: buf_count unchanged, both pointers advance.
- AXI-style stream rules:
  - Once asserted, m_valid stays high and m_data stays stable until pop.
  - m_valid does not depend on m_ready.
- Latency:
  - Read issued in cycle N (rd_en=1 in cycle N).
  - Data captured at the N+1 edge.
  - m_valid=1 in cycle N+2 (first word), i.e. 2 cycles after fifo_empty falls when idle.
- Throughput: with BUF_DEPTH>=2 and m_ready held high, fifo_rd_en stays high continuously and one word is delivered per cycle.
- Back-pressure (m_ready=0):
  - Buffer fills; fifo_rd_en drops once buf_count+inflight reaches BUF_DEPTH.
  - The in-flight word is still captured, into the last free slot.
- FIFO goes empty mid-burst: fifo_rd_en drops the same cycle; the already in-flight word is still captured; no spurious capture follows.
- words_out: increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- Order: words are delivered in exactly FIFO read order. Duplication and drops are illegal.
- Reset mid-operation: in-flight and buffered words are discarded; after rst_n rises, operation restarts from the empty state.

Test Plan:
- Reset hold: rst_n=0 for 5 cycles with the FIFO non-empty -> fifo_rd_en=0, m_valid=0, buf_count=0, words_out=0 throughout.
- Single word, m_ready=1: FIFO holds 0xA5A5 and fifo_empty falls at cycle 0.
  - fifo_rd_en=1 in cycle 0.
  - m_valid=1 with m_data=0xA5A5 in cycle 2.
  - words_out=1 after the cycle-2 edge.
- Streaming: FIFO holds 8 words 0x0001..0x0008, m_ready=1 -> fifo_rd_en high for 8 consecutive cycles, 8 consecutive pops in order, words_out=8.
- Back-pressure: 8 words queued, m_ready=0 for 10 cycles.
  - buf_count reaches 2.
  - fifo_rd_en=0 after 2 reads.
  - After m_ready=1, the remaining words 0x0001..0x0008 drain in order with no loss.
- Random stress: 1000 cycles of random FIFO writes and random m_ready, checked against a scoreboard queue.
  - Output sequence equals the input sequence.
  - fifo_rd_en never asserts when fifo_empty=1.
  - buf_count never exceeds BUF_DEPTH.
- Reset during burst: assert rst_n=0 while buf_count=2 and inflight=1 -> all outputs clear immediately; after release, a new word 0x1234 streams with the standard 2-cycle latency.

Source files
------------

// File: rtl/fifo_stream_reader.sv
//----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side consumer for a synchronous FIFO whose data output is registered
// (1-cycle read latency). Words read from the FIFO land in a small circular
// holding buffer and are re-presented on a valid/ready stream. Reads are
// credit controlled, so the buffer cannot overflow and the FIFO is never read
// while empty. With BUF_DEPTH >= 2 one word per cycle is sustained.
//
// Ports:
//   clk            in   system clock, rising-edge
//   rst_n          in   asynchronous active-low reset (shared with the FIFO)
//   fifo_empty     in   FIFO empty flag
//   fifo_data_out  in   FIFO registered read data, valid the cycle after a read
//   fifo_rd_en     out  FIFO read enable (combinational)
//   m_data         out  stream data, buffer head entry
//   m_valid        out  stream valid (buffer not empty)
//   m_ready        in   downstream ready
//   buf_count      out  number of words held in the buffer
//   words_out      out  count of completed stream handshakes (wraps)
//----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fifo_empty,
    input  logic [FIFO_WIDTH-1:0]          fifo_data_out,
    output logic                           fifo_rd_en,
    output logic [FIFO_WIDTH-1:0]          m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
    output logic [CNT_WIDTH-1:0]           words_out
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(BUF_DEPTH);

    // Holding buffer and its bookkeeping
    logic [FIFO_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_words;

    logic                  w_pop;
    logic                  w_capture;
    logic [CW:0]           w_credit;
    logic                  w_rd_en;

    // Circular pointer advance; BUF_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_pop     = m_valid & m_ready;
    assign w_capture = r_inflight;

    // Occupancy the buffer will have once the in-flight word lands and the
    // current pop retires. One bit wider than r_count so it cannot wrap; pop
    // implies r_count >= 1, so the subtraction never underflows.
    assign w_credit = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);

    // rst_n gates the enable so no read is issued while the FIFO is in reset.
    assign w_rd_en = rst_n & ~fifo_empty & (w_credit < DEPTH_L);

    // In-flight tracker: the FIFO presents data one cycle after an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Buffer storage. The in-flight word is written unconditionally because
    // the read that produced it was issued only while the FIFO was non-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_capture) begin
            r_mem[r_tail] <= fifo_data_out;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_capture) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
        end else if (w_pop) begin
            r_words <= r_words + 1'b1;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_data     = r_mem[r_head];
    assign m_valid    = (r_count != '0);
    assign buf_count  = r_count;
    assign words_out  = r_words;

endmodule
